// File: rtl/adc_capture_ctrl.sv
// Capture controller: records CapLast+1 multi-channel ADC frames into BRAM on a CapStart rise.
// Optional decimation is enabled by defining ADC_CAP_DECIM_EN (adds the CapDecim port).
module adc_capture_ctrl #(
  parameter int C_AdcChnls    = 8,
  parameter int C_AdcSmplBits = 16,
  parameter int C_AddrBits    = 14
) (
  input  logic                                AdcFrmClk,
  input  logic                                SysRst_n,
  input  logic                                AdcDataValid,
  input  logic [C_AdcChnls*C_AdcSmplBits-1:0] AdcData,
  input  logic                                CapStart,
  input  logic [C_AddrBits-1:0]               CapLast,
`ifdef ADC_CAP_DECIM_EN
  input  logic [7:0]                          CapDecim,
`endif
  output logic                                CapBusy,
  output logic                                CapDone,
  output logic                                CapAbort,
  output logic [C_AddrBits-1:0]               BramAddr,
  output logic [C_AdcChnls*C_AdcSmplBits-1:0] BramDin,
  output logic                                BramWe
);
  typedef enum logic [1:0] {IDLE, CAPT, DONE} state_t;

  state_t                state;
  logic                  start_s1, start_s2, start_prev;
  logic                  start_edge;
  logic [C_AddrBits-1:0] last;
  logic                  wr_frm;

  assign start_edge = start_s2 & ~start_prev;

`ifdef ADC_CAP_DECIM_EN
  logic [7:0] decim, dcnt;
  // dcnt counts frames since the last write; a frame is written once it reaches the latched ratio
  assign wr_frm = (dcnt == decim);
`else
  assign wr_frm = 1'b1;
`endif

  always_ff @(posedge AdcFrmClk or negedge SysRst_n) begin
    if (!SysRst_n) begin
      start_s1   <= 1'b0;
      start_s2   <= 1'b0;
      start_prev <= 1'b0;
      state      <= IDLE;
      last       <= '0;
      CapBusy    <= 1'b0;
      CapDone    <= 1'b0;
      CapAbort   <= 1'b0;
      BramWe     <= 1'b0;
      BramAddr   <= '0;
      BramDin    <= '0;
`ifdef ADC_CAP_DECIM_EN
      decim      <= '0;
      dcnt       <= '0;
`endif
    end else begin
      start_s1   <= CapStart;
      start_s2   <= start_s1;
      start_prev <= start_s2;
      case (state)
        IDLE: begin
          BramWe   <= 1'b0;
          BramAddr <= '0;
          BramDin  <= '0;
          if (start_edge && AdcDataValid) begin
            state    <= CAPT;
            last     <= CapLast;
            CapBusy  <= 1'b1;
            CapDone  <= 1'b0;
            CapAbort <= 1'b0;
            BramWe   <= 1'b1;
            BramDin  <= AdcData;
`ifdef ADC_CAP_DECIM_EN
            decim    <= CapDecim;
            dcnt     <= '0;
`endif
          end
        end
        CAPT: begin
          // Completion wins over a dropped link: every requested frame is already stored.
          if (BramWe && BramAddr == last) begin
            state    <= DONE;
            BramWe   <= 1'b0;
            BramAddr <= '0;
            BramDin  <= '0;
          end else if (!AdcDataValid) begin
            state    <= IDLE;
            CapBusy  <= 1'b0;
            CapAbort <= 1'b1;
            BramWe   <= 1'b0;
            BramAddr <= '0;
            BramDin  <= '0;
          end else begin
            BramWe <= wr_frm;
            if (wr_frm) begin
              BramAddr <= BramAddr + 1'b1;
              BramDin  <= AdcData;
            end
`ifdef ADC_CAP_DECIM_EN
            dcnt <= wr_frm ? 8'd0 : dcnt + 8'd1;
`endif
          end
        end
        DONE: begin
          state   <= IDLE;
          CapBusy <= 1'b0;
          CapDone <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Bench for adc_capture_ctrl: per-cycle behavioural model compare plus directed literal checks.
module tb_adc_capture_ctrl;
  localparam int NCH = 8, SW = 16, AW = 14, DW = NCH * SW;

  logic          clk = 1'b0, rst_n = 1'b0, valid = 1'b1, start = 1'b0;
  logic [DW-1:0] data;
  logic [AW-1:0] cap_last = '0;
`ifdef ADC_CAP_DECIM_EN
  logic [7:0]    cap_decim = '0;
`endif
  logic          busy, done, abort, we;
  logic [AW-1:0] addr;
  logic [DW-1:0] din;

  int checks = 0, errors = 0;
  int fc = 0;

  adc_capture_ctrl dut (
    .AdcFrmClk(clk), .SysRst_n(rst_n), .AdcDataValid(valid), .AdcData(data),
    .CapStart(start), .CapLast(cap_last),
`ifdef ADC_CAP_DECIM_EN
    .CapDecim(cap_decim),
`endif
    .CapBusy(busy), .CapDone(done), .CapAbort(abort),
    .BramAddr(addr), .BramDin(din), .BramWe(we)
  );

  always #5 clk = ~clk;

  // ramp data: channel n carries frame counter + 256*n
  always @(posedge clk) begin #1; fc = fc + 1; end
  always @* for (int n = 0; n < NCH; n++) data[n*SW +: SW] = SW'(fc + n * 256);

  // ---------------- behavioural model ----------------
  int   ph = 0, nfr = 0, nwr = 0, mlast = 0, mdec = 0;
  bit   p1 = 0, p2 = 0, p3 = 0, se = 0, din_chk = 1;
  logic e_busy = 0, e_done = 0, e_abort = 0, e_we = 0;
  logic [AW-1:0] e_addr = '0;
  logic [DW-1:0] e_din = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph = 0; p1 = 0; p2 = 0; p3 = 0;
      e_busy = 0; e_done = 0; e_abort = 0; e_we = 0; e_addr = '0; e_din = '0; din_chk = 1;
    end else begin
      se = p2 & ~p3;
      p3 = p2; p2 = p1; p1 = start;
      case (ph)
        0: begin
          e_we = 0; e_addr = '0; e_din = '0; din_chk = 1;
          if (se && valid) begin
            ph = 1; nfr = 0; nwr = 1; mlast = int'(cap_last);
`ifdef ADC_CAP_DECIM_EN
            mdec = int'(cap_decim);
`else
            mdec = 0;
`endif
            e_we = 1; e_din = data; e_busy = 1; e_done = 0; e_abort = 0;
          end
        end
        1: begin
          if (nwr == mlast + 1) begin
            ph = 2; e_we = 0; e_addr = '0; e_din = '0; din_chk = 1;
          end else if (!valid) begin
            ph = 0; e_busy = 0; e_abort = 1; e_we = 0; e_addr = '0; e_din = '0; din_chk = 1;
          end else begin
            nfr++;
            if (nfr % (mdec + 1) == 0) begin
              e_we = 1; e_addr = AW'(nwr); e_din = data; nwr++; din_chk = 1;
            end else begin
              e_we = 0; din_chk = 0;
            end
          end
        end
        default: begin ph = 0; e_busy = 0; e_done = 1; end
      endcase
    end
  end

  always @(negedge clk) begin
    checks++;
    if (busy !== e_busy || done !== e_done || abort !== e_abort || we !== e_we ||
        addr !== e_addr || (din_chk && din !== e_din)) begin
      errors++;
      $display("FAIL model t=%0t: busy/done/abort/we/addr=%b/%b/%b/%b/%0d din=%h, expected %b/%b/%b/%b/%0d din=%h",
               $time, busy, done, abort, we, addr, din, e_busy, e_done, e_abort, e_we, e_addr, e_din);
    end
  end

  // ---------------- write log ----------------
  typedef struct { int a; int d; int c; } wr_t;
  wr_t wlog[$];
  int  done_cyc = 0;
  logic done_q = 0;
  always @(negedge clk) begin
    if (we) wlog.push_back('{int'(addr), int'(din[SW-1:0]), fc});
    if (done && !done_q) done_cyc = fc;
    done_q = done;
  end

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_idle(string name);
    int ok = 0;
    for (int i = 0; i < 200; i++) begin
      if (!busy) begin ok = 1; break; end
      tick(1);
    end
    chk({name, "_timeout"}, ok, 1);
  endtask

  task automatic wait_writes(string name, int n);
    int ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (wlog.size() >= n) begin ok = 1; break; end
    end
    chk({name, "_timeout"}, ok, 1);
  endtask

  task automatic run_capture(int last_v, output logic done_mid);
    wlog.delete();
    cap_last = AW'(last_v);
    start = 1; tick(4); start = 0;
    done_mid = done;
    wait_idle("run");
    tick(1);
  endtask

  logic dm;

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(2);
    chk("reset_outputs", int'({busy, done, abort, we, addr, din} == '0), 1);
    rst_n = 1;
    tick(3);

    // four-frame capture with ramp data
    run_capture(3, dm);
    chk("l3_count", wlog.size(), 4);
    for (int k = 0; k < wlog.size(); k++) begin
      chk("l3_addr", wlog[k].a, k);
      chk("l3_data", wlog[k].d, (wlog[0].d + k) & 16'hffff);
    end
    chk("l3_done", int'(done), 1);
    chk("l3_done_lat", done_cyc - wlog[wlog.size()-1].c, 2);

    // single-frame capture, then repeat: done clears then sets again
    run_capture(0, dm);
    chk("l0_count", wlog.size(), 1);
    chk("l0_addr", wlog[0].a, 0);
    chk("l0_done", int'(done), 1);
    run_capture(0, dm);
    chk("l0_done_cleared", int'(dm), 0);
    chk("l0_done_again", int'(done), 1);

    // link drop after write 2 of a ten-frame capture
    wlog.delete();
    cap_last = AW'(9);
    start = 1;
    wait_writes("abort", 3);
    valid = 0; start = 0;
    tick(3);
    chk("abort_count", wlog.size(), 3);
    chk("abort_flag", int'(abort), 1);
    chk("abort_done", int'(done), 0);
    chk("abort_busy", int'(busy), 0);
    valid = 1;
    tick(3);

    // start toggled mid-capture: no restart
    wlog.delete();
    cap_last = AW'(9);
    start = 1; tick(4); start = 0; tick(2); start = 1; tick(4); start = 0;
    wait_idle("toggle");
    tick(2);
    chk("toggle_count", wlog.size(), 10);
    chk("toggle_last_addr", wlog[wlog.size()-1].a, 9);
    chk("toggle_done", int'(done), 1);

    // start rise with link down: ignored and not queued
    wlog.delete();
    valid = 0; start = 1; tick(6);
    valid = 1; tick(6);
    start = 0; tick(4);
    chk("nolink_count", wlog.size(), 0);
    chk("nolink_done", int'(done), 1);
    chk("nolink_busy", int'(busy), 0);

    // reset during write 5
    wlog.delete();
    cap_last = AW'(9);
    start = 1;
    wait_writes("rst", 6);
    rst_n = 0; #1;
    chk("rst_mid_outputs", int'({busy, done, abort, we, addr, din} == '0), 1);
    start = 0;
    tick(2);
    rst_n = 1;
    wlog.delete();
    tick(10);
    chk("rst_no_writes", wlog.size(), 0);
    chk("rst_busy", int'(busy), 0);

`ifdef ADC_CAP_DECIM_EN
    cap_decim = 8'd2;
    run_capture(2, dm);
    chk("dec_count", wlog.size(), 3);
    for (int k = 0; k < wlog.size(); k++) chk("dec_addr", wlog[k].a, k);
    for (int k = 1; k < wlog.size(); k++) begin
      chk("dec_gap", wlog[k].c - wlog[k-1].c, 3);
      chk("dec_data", wlog[k].d - wlog[k-1].d, 3);
    end
    cap_decim = 8'd0;
    tick(2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/adc_capture_ctrl.md
# adc_capture_ctrl

Parametrised capture controller between the LVDS ADC deserialiser and the PS-visible capture BRAM, clocked in the ADC frame-clock domain. On a rising edge of a software start request it records a programmable number of multi-channel sample frames into consecutive BRAM addresses. It then raises a sticky done flag for the processor to poll. It generalises the fixed 8×16-bit capture loop to any channel count, sample width and depth, adds abort reporting when the ADC link drops, and offers optional decimation.

## Interface
Parameters:
- C_AdcChnls, 8, number of ADC channels packed per BRAM word
- C_AdcSmplBits, 16, bits per channel sample
- C_AddrBits, 14, BRAM address width; maximum capture 2^C_AddrBits frames

Ports:
- AdcFrmClk  in  1  frame clock; all logic on its rising edge
- SysRst_n  in  1  asynchronous active-low reset
- AdcDataValid  in  1  deserialiser locked/aligned; frames valid while 1
- AdcData  in  C_AdcChnls*C_AdcSmplBits  channel n at bits [n*C_AdcSmplBits +: C_AdcSmplBits]
- CapStart  in  1  start request from the PS GPIO, asynchronous to AdcFrmClk
- CapLast  in  C_AddrBits  last address to write; frames captured = CapLast+1
- CapDecim  in  8  decimation ratio minus 1 (present only with ADC_CAP_DECIM_EN)
- CapBusy  out  1  capture in progress
- CapDone  out  1  sticky: last capture completed
- CapAbort  out  1  sticky: last capture aborted by loss of AdcDataValid
- BramAddr  out  C_AddrBits  write address
- BramDin  out  C_AdcChnls*C_AdcSmplBits  write data
- BramWe  out  1  write enable

## Operation
- CapStart passes through a 2-flop synchroniser plus an edge register; StartEdge = sync=1 and previous=0.
- States: IDLE, CAPT, DONE.
- IDLE: BramWe=0, BramAddr=0, BramDin=0. On StartEdge with AdcDataValid=1: latch CapLast (and CapDecim), clear CapDone/CapAbort, go to CAPT and issue the first write (address 0) on the same edge.
- StartEdge while AdcDataValid=0: ignored, not queued; sticky flags unchanged.
- CAPT: one write per accepted frame, address incrementing by 1. After the write at the latched CapLast, go to DONE.
- CAPT with AdcDataValid=0 sampled: go to IDLE on the next edge. Set CapAbort=1, clear BramWe, and leave CapDone=0.
- DONE: one cycle with BramWe=0 and address/data cleared, then set CapDone=1 and go to IDLE.
- StartEdge during CAPT/DONE: ignored.
- CapLast/CapDecim changes during a capture have no effect, because latched values are used.
- CapBusy=1 exactly in CAPT and DONE.
- The address never wraps. CapLast = all-ones yields 2^C_AddrBits writes.

## Timing
- Reset: CapBusy=0, CapDone=0, CapAbort=0, BramWe=0, BramAddr=0, BramDin=0, synchroniser and edge regs 0, state IDLE.
- CapStart rise → StartEdge: 2–3 cycles (synchroniser).
- StartEdge in cycle t → at edge t+1: BramWe=1, BramAddr=0, BramDin = AdcData sampled in cycle t, CapBusy=1.
- Undecimated: writes on consecutive cycles, addr k at edge t+1+k. The last write is at t+1+CapLast; BramWe=0 at t+2+CapLast (DONE); CapDone=1 and CapBusy=0 at t+3+CapLast.
- Abort: AdcDataValid=0 in cycle u → at edge u+1: BramWe=0, CapAbort=1, CapBusy=0. No write occurs for frame u.
- BramDin is always registered; data-to-write latency is 1 cycle.

## Configuration
- ADC_CAP_DECIM_EN defined: the CapDecim port exists. In CAPT, a frame is written every CapDecim+1 valid frames, starting with the first. Between writes, BramWe=0 and BramAddr holds the last written value. CapDecim=0 behaves exactly as undecimated.
- ADC_CAP_DECIM_EN undefined: no CapDecim port and no divider counter; every frame in CAPT is written.

## Test plan
- Reset mid-capture (SysRst_n low at write 5) → all outputs 0 immediately; after release, no writes until a new CapStart rise.
- CapLast=3, constant-ramp AdcData (ch0 = frame index), CapStart rise → exactly 4 writes at addresses 0..3 with ch0 data consecutive; CapDone=1 two cycles after the last write; CapBusy high throughout.
- CapLast=0 → single write at address 0, CapDone=1; a second CapStart rise clears CapDone, then sets it again.
- AdcDataValid dropped after write 2 of CapLast=9 → writes 0..2 only, CapAbort=1, CapDone=0, BramWe=0 next edge.
- CapStart toggled during CAPT, and CapStart rise with AdcDataValid=0 → no restart, no queued capture, write count unchanged.
- With ADC_CAP_DECIM_EN, CapDecim=2, CapLast=2 → writes at frames 0, 3, 6 to addresses 0, 1, 2; BramWe=0 in the cycles between.
